// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

  // Sequencer modes; MEM_WAIT remembers whether it interrupted RUN or DRAIN
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrlState_e;

  // Advancing cycles spent draining before the pipeline counts as empty
  localparam int DRAIN_CYCLES = 4;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a source operand is really read and names the load's destination
  function automatic logic srcHit(input logic uses, input logic [4:0] src,
                                  input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over increment; the count sticks once it reaches all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory waits and a debug halt/drain sequence.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             pipe_hold_o,
  output logic             mem_wb_bubble_o,
  output logic             halt_ack_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int                     WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  ctrlState_e             state_q;
  ctrlState_e             state_d;
  ctrlState_e             retState_q;
  ctrlState_e             retState_d;
  logic [DRAIN_CNT_W-1:0] drainCnt_q;
  logic [DRAIN_CNT_W-1:0] drainCnt_d;
  logic [WAIT_W-1:0]      waitCnt_q;
  logic [WAIT_W-1:0]      waitCnt_d;
  logic                   timeout_q;
  logic                   timeout_d;

  ctrlState_e effState;
  logic       active;
  logic       freeze;
  logic       branch;
  logic       loadUse;
  logic       advance;

  // Classify the current cycle: freeze beats branch, branch beats load-use
  always_comb begin
    effState = (state_q == MEM_WAIT) ? retState_q : state_q;
    active   = (state_q != HALTED);
    freeze   = active && !mem_ready_i && ((state_q == MEM_WAIT) || mem_req_i);
    branch   = active && !freeze && branch_taken_i;
    loadUse  = active && !freeze && !branch && id_ex_memread_i &&
               (id_ex_rd_i != REG_ZERO) &&
               (srcHit(id_uses_rs1_i, id_rs1_i, id_ex_rd_i) ||
                srcHit(id_uses_rs2_i, id_rs2_i, id_ex_rd_i));
    advance  = active && !freeze && !loadUse;
  end

  // Pipeline register controls, combinational from state and inputs
  always_comb begin
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_flush_o  = 1'b0;
    pipe_hold_o     = 1'b0;
    mem_wb_bubble_o = 1'b0;
    halt_ack_o      = 1'b0;
    if (reset) begin
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_flush_o  = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (state_q == HALTED) begin
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_flush_o  = 1'b1;
      mem_wb_bubble_o = 1'b1;
      halt_ack_o      = 1'b1;
    end else if (freeze) begin
      pipe_hold_o     = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (branch) begin
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_flush_o  = 1'b1;
    end else if (loadUse) begin
      id_ex_flush_o   = 1'b1;
    end else if (effState == DRAIN) begin
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b1;
    end else begin
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
    end
  end

  // Next-state logic for the mode FSM, drain progress and memory-wait watchdog
  always_comb begin
    state_d    = state_q;
    retState_d = retState_q;
    drainCnt_d = drainCnt_q;
    waitCnt_d  = waitCnt_q;
    timeout_d  = timeout_q;

    if (state_q == MEM_WAIT) begin
      if (waitCnt_q != WAIT_LIMIT) begin
        waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
      if (waitCnt_d == WAIT_LIMIT) begin
        timeout_d = 1'b1;
      end
    end

    if (state_q == HALTED) begin
      if (!halt_req_i) begin
        state_d = RUN;
      end
    end else if (freeze) begin
      if (state_q != MEM_WAIT) begin
        state_d    = MEM_WAIT;
        retState_d = state_q;
        waitCnt_d  = '0;
      end
    end else if (effState == DRAIN) begin
      state_d = DRAIN;
      if (advance) begin
        if (drainCnt_q == DRAIN_LAST) begin
          state_d = HALTED;
        end else begin
          drainCnt_d = drainCnt_q + DRAIN_CNT_W'(1);
        end
      end
    end else begin
      state_d = RUN;
      if (halt_req_i && !loadUse) begin
        state_d    = DRAIN;
        drainCnt_d = '0;
      end
    end
  end

  // State registers; reset aborts any wait or drain straight back to RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      retState_q <= RUN;
      drainCnt_q <= '0;
      waitCnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retState_q <= retState_d;
      drainCnt_q <= drainCnt_d;
      waitCnt_q  <= waitCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout_o = timeout_q;

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (freeze || loadUse),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (branch),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a small counters/watchdog
// configuration so saturation and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int TB_CNT_W    = 4;
  localparam int TB_MAX_WAIT = 4;
  localparam int CNT_MAX     = (1 << TB_CNT_W) - 1;

  localparam int M_RUN   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic       halt;
  } stim_t;

  typedef struct packed {
    logic [7:0]          ctl;
    logic [TB_CNT_W-1:0] stall;
    logic [TB_CNT_W-1:0] flush;
    logic                tout;
    logic                regsKnown;
  } exp_t;

  logic                clk;
  logic                reset;
  logic [4:0]          idRs1;
  logic [4:0]          idRs2;
  logic                idUsesRs1;
  logic                idUsesRs2;
  logic                idExMemread;
  logic [4:0]          idExRd;
  logic                branchTaken;
  logic                memReq;
  logic                memReady;
  logic                haltReq;
  logic                pcWrite;
  logic                ifIdWrite;
  logic                ifIdFlush;
  logic                idExFlush;
  logic                exMemFlush;
  logic                pipeHold;
  logic                memWbBubble;
  logic                haltAck;
  logic                memTimeout;
  logic [TB_CNT_W-1:0] stallCycles;
  logic [TB_CNT_W-1:0] flushCount;

  pipeline_hazard_ctrl #(
    .CNT_W    (TB_CNT_W),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1_i        (idRs1),
    .id_rs2_i        (idRs2),
    .id_uses_rs1_i   (idUsesRs1),
    .id_uses_rs2_i   (idUsesRs2),
    .id_ex_memread_i (idExMemread),
    .id_ex_rd_i      (idExRd),
    .branch_taken_i  (branchTaken),
    .mem_req_i       (memReq),
    .mem_ready_i     (memReady),
    .halt_req_i      (haltReq),
    .pc_write_o      (pcWrite),
    .if_id_write_o   (ifIdWrite),
    .if_id_flush_o   (ifIdFlush),
    .id_ex_flush_o   (idExFlush),
    .ex_mem_flush_o  (exMemFlush),
    .pipe_hold_o     (pipeHold),
    .mem_wb_bubble_o (memWbBubble),
    .halt_ack_o      (haltAck),
    .mem_timeout_o   (memTimeout),
    .stall_cycles_o  (stallCycles),
    .flush_count_o   (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t sb[$];

  // Reference model state
  int mState     = M_RUN;
  int mRet       = M_RUN;
  int mDrainLeft = 0;
  int mWaitSeen  = 0;
  int mStall     = 0;
  int mFlush     = 0;
  bit mTout      = 1'b0;
  bit mKnown     = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then step the model
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   frozen;
    bit   hazard;
    int   mode;
    int   oldState;
    @(posedge clk);
    #1;
    reset       = s.rst;
    idRs1       = s.rs1;
    idRs2       = s.rs2;
    idUsesRs1   = s.u1;
    idUsesRs2   = s.u2;
    idExMemread = s.mr;
    idExRd      = s.rd;
    branchTaken = s.br;
    memReq      = s.mreq;
    memReady    = s.mrdy;
    haltReq     = s.halt;

    e.regsKnown = mKnown;
    e.stall     = TB_CNT_W'(mStall);
    e.flush     = TB_CNT_W'(mFlush);
    e.tout      = mTout;

    oldState = mState;
    hazard   = s.mr && (s.rd != 5'd0) &&
               ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));

    if (s.rst) begin
      e.ctl      = 8'b0011_1010;
      mState     = M_RUN;
      mRet       = M_RUN;
      mDrainLeft = 0;
      mWaitSeen  = 0;
      mStall     = 0;
      mFlush     = 0;
      mTout      = 1'b0;
      mKnown     = 1'b1;
    end else if (mState == M_HALT) begin
      e.ctl = 8'b0011_1011;
      if (!s.halt) mState = M_RUN;
    end else begin
      if (oldState == M_WAIT) begin
        mWaitSeen++;
        if (mWaitSeen >= TB_MAX_WAIT) mTout = 1'b1;
      end
      frozen = !s.mrdy && ((mState == M_WAIT) || s.mreq);
      mode   = (mState == M_WAIT) ? mRet : mState;
      if (frozen) begin
        e.ctl = 8'b0000_0110;
        if (mStall < CNT_MAX) mStall++;
        if (mState != M_WAIT) begin
          mRet      = mState;
          mState    = M_WAIT;
          mWaitSeen = 0;
        end
      end else begin
        if (s.br) begin
          e.ctl = 8'b1111_1000;
          if (mFlush < CNT_MAX) mFlush++;
        end else if (hazard) begin
          e.ctl = 8'b0001_0000;
          if (mStall < CNT_MAX) mStall++;
        end else if (mode == M_DRAIN) begin
          e.ctl = 8'b0110_0000;
        end else begin
          e.ctl = 8'b1100_0000;
        end
        if (mode == M_DRAIN) begin
          mState = M_DRAIN;
          if (s.br || !hazard) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mState = M_HALT;
          end
        end else begin
          mState = M_RUN;
          if (s.halt && (s.br || !hazard)) begin
            mState     = M_DRAIN;
            mDrainLeft = 4;
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  // Compare DUT outputs against the oldest prediction, mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("ctl", {24'd0, pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
                          pipeHold, memWbBubble, haltAck}, {24'd0, e.ctl});
      if (e.regsKnown) begin
        checkOutput("stall_cycles", 32'(stallCycles), 32'(e.stall));
        checkOutput("flush_count", 32'(flushCount), 32'(e.flush));
        checkOutput("mem_timeout", 32'(memTimeout), 32'(e.tout));
      end
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s      = '0;
    s.mrdy = 1'b1;
    return s;
  endfunction

  task automatic runIdle(input int n, input bit halt);
    stim_t s;
    s      = idleStim();
    s.halt = halt;
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    bit    haltLvl;
    reset = 1'b1; idRs1 = '0; idRs2 = '0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
    idExMemread = 1'b0; idExRd = '0; branchTaken = 1'b0; memReq = 1'b0;
    memReady = 1'b1; haltReq = 1'b0;

    // Reset
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    runIdle(2, 1'b0);

    // Load-use on rs2, then the same pattern with rd = x0, then unused rs1 match
    s = idleStim(); s.mr = 1'b1; s.rd = 5'd5; s.u2 = 1'b1; s.rs2 = 5'd5;
    applyStimulus(s);
    runIdle(1, 1'b0);
    s.rd = 5'd0; s.rs2 = 5'd0;
    applyStimulus(s);
    s = idleStim(); s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0; s.u2 = 1'b1; s.rs2 = 5'd3;
    applyStimulus(s);
    s.u1 = 1'b1;
    applyStimulus(s);
    runIdle(1, 1'b0);

    // Branch alone, then branch with a load-use match
    s = idleStim(); s.br = 1'b1;
    applyStimulus(s);
    runIdle(1, 1'b0);
    s.mr = 1'b1; s.rd = 5'd9; s.u1 = 1'b1; s.rs1 = 5'd9;
    applyStimulus(s);
    runIdle(1, 1'b0);

    // Three-cycle memory wait, branch ignored while frozen
    s = idleStim(); s.mreq = 1'b1; s.mrdy = 1'b0; s.br = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.mrdy = 1'b1;
    applyStimulus(s);
    runIdle(1, 1'b0);

    // Watchdog: six not-ready cycles, then reset while still waiting
    s = idleStim(); s.mreq = 1'b1; s.mrdy = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    runIdle(2, 1'b0);

    // Clean halt and release
    runIdle(7, 1'b1);
    runIdle(2, 1'b0);

    // Halt with load-use, branch and a memory wait inside the drain
    runIdle(2, 1'b1);
    s = idleStim(); s.halt = 1'b1; s.mr = 1'b1; s.rd = 5'd4; s.u2 = 1'b1; s.rs2 = 5'd4;
    applyStimulus(s);
    s = idleStim(); s.halt = 1'b1; s.br = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.halt = 1'b1; s.mreq = 1'b1; s.mrdy = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    s.mrdy = 1'b1;
    applyStimulus(s);
    runIdle(6, 1'b1);
    runIdle(2, 1'b0);

    // Counter saturation
    s = idleStim(); s.mr = 1'b1; s.rd = 5'd12; s.u1 = 1'b1; s.rs1 = 5'd12;
    for (int i = 0; i < 20; i++) applyStimulus(s);
    s = idleStim(); s.br = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(s);

    // Random traffic
    haltLvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      s      = '0;
      s.rst  = ($urandom_range(0, 99) < 2);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.mr   = 1'($urandom_range(0, 1));
      s.rd   = 5'($urandom_range(0, 3));
      s.br   = ($urandom_range(0, 99) < 15);
      s.mreq = ($urandom_range(0, 99) < 30);
      s.mrdy = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 10) haltLvl = !haltLvl;
      s.halt = haltLvl;
      applyStimulus(s);
    end

    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    runIdle(2, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
